// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one pipelined multiplier between NREQ requesters.
// Operand pairs are granted round-robin and issued together on the a/b ports.
// The ID of each issuing requester is queued in an in-flight FIFO so every
// returning result is steered back to its owner, in issue order.
// Build option: define MULT_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest requester index wins and no priority pointer register exists.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic [NREQ-1:0]       o_res_valid,
    input  logic [NREQ-1:0]       i_res_ready,
    output logic [WIDTH-1:0]      o_res_data,
    output logic                  o_mul_a_valid,
    output logic                  o_mul_b_valid,
    input  logic                  i_mul_a_ready,
    input  logic                  i_mul_b_ready,
    output logic [WIDTH-1:0]      o_mul_a,
    output logic [WIDTH-1:0]      o_mul_b,
    input  logic                  i_mul_result_valid,
    output logic                  o_mul_result_ready,
    input  logic [WIDTH-1:0]      i_mul_result,
    output logic                  o_err
);

    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [IDW-1:0] ptr_s;
    logic [IDW-1:0] gid_s;
    logic [IDW-1:0] cand_s;
    logic           any_req_s;
    logic           issue_valid_s;
    logic           fire_s;
    logic           empty_s;
    logic           full_s;
    logic [IDW-1:0] head_s;
    logic           h_s;
    logic           pop_s;

    logic [IDW-1:0] id_mem_r [MAX_OUT];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           err_r;

    // Requester index 'off' positions after 'base', wrapping modulo NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return IDW'(sum);
    endfunction

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign ptr_s = {IDW{1'b0}};
`else
    logic [IDW-1:0] ptr_r;

    // Priority pointer: after an issue, searching restarts just past the winner.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r <= {IDW{1'b0}};
        end else if (fire_s) begin
            if (gid_s == IDW'(NREQ - 1)) begin
                ptr_r <= {IDW{1'b0}};
            end else begin
                ptr_r <= gid_s + IDW'(1'b1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    assign any_req_s = |i_req_valid;

    // Grant search: walk backwards so the valid requester closest to the pointer wins.
    always_comb begin
        gid_s  = {IDW{1'b0}};
        cand_s = {IDW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_s = wrap_add(ptr_s, i);
            gid_s  = i_req_valid[cand_s] ? cand_s : gid_s;
        end
    end

    // Issue is blocked when full, even if a result pops in the same cycle.
    assign empty_s       = (count_r == {CW{1'b0}});
    assign full_s        = (count_r == CW'(MAX_OUT));
    assign issue_valid_s = reset_n && any_req_s && !full_s;
    assign fire_s        = issue_valid_s && i_mul_a_ready && i_mul_b_ready;

    assign o_mul_a_valid = issue_valid_s;
    assign o_mul_b_valid = issue_valid_s;
    assign o_mul_a       = i_req_a[gid_s*WIDTH +: WIDTH];
    assign o_mul_b       = i_req_b[gid_s*WIDTH +: WIDTH];

    // Accept strobe goes only to the granted requester, and only when issued.
    always_comb begin
        o_req_ready        = {NREQ{1'b0}};
        o_req_ready[gid_s] = fire_s;
    end

    // Result return: the FIFO head owns whatever the multiplier presents.
    assign head_s             = id_mem_r[rd_ptr_r];
    assign h_s                = reset_n && i_mul_result_valid && !empty_s;
    assign pop_s              = h_s && i_res_ready[head_s];
    assign o_mul_result_ready = pop_s;
    assign o_res_data         = i_mul_result;

    // Result valid is steered to the head owner only.
    always_comb begin
        o_res_valid         = {NREQ{1'b0}};
        o_res_valid[head_s] = h_s;
    end

    // ID storage: data-only, validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (fire_s) begin
            id_mem_r[wr_ptr_r] <= gid_s;
        end else begin
            id_mem_r[wr_ptr_r] <= id_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= fire_s ? wr_ptr_r + PW'(1'b1) : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + PW'(1'b1) : rd_ptr_r;
            case ({fire_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error: a result arrived with nothing in flight to own it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (i_mul_result_valid && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign o_err = err_r;

endmodule
